// File: rtl/sequence_player.sv
// Playback side of the sequence ROM: fetches entries 0..len-1 and shows each
// as a one-hot LED for ON_TICKS ticks followed by an OFF_TICKS dark gap.
module sequence_player #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned ON_TICKS  = 2,
    parameter int unsigned OFF_TICKS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] length,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [1:0]        rd_data,
    output logic [3:0]        led,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] pos
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ON,
        S_OFF,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        entry_q, entry_d;
    logic [3:0]        led_q, led_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] len_eff_c;
    logic [CNT_W-1:0]  cnt_inc_c;

    function automatic logic [3:0] onehot(input logic [1:0] v);
        return 4'b0001 << v;
    endfunction

    assign len_eff_c = (length > ADDR_W'(DEPTH)) ? ADDR_W'(DEPTH) : length;
    assign cnt_inc_c = cnt_q + CNT_W'(1);

    // idx doubles as the ROM address and the visible position; it holds in IDLE
    assign rd_addr = idx_q;
    assign pos     = idx_q;
    assign led     = led_q;
    assign busy    = busy_q;
    assign done    = done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            entry_q <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            entry_q <= entry_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state plus next values of every registered output
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        entry_d = entry_q;
        led_d   = 4'b0000;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    len_d   = len_eff_c;
                    idx_d   = '0;
                    state_d = (len_eff_c == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                entry_d = rd_data;
                cnt_d   = '0;
                led_d   = onehot(rd_data);
                state_d = S_ON;
            end
            S_ON: begin
                led_d = onehot(entry_q);
                if (tick) begin
                    if (cnt_inc_c == CNT_W'(ON_TICKS)) begin
                        cnt_d   = '0;
                        led_d   = 4'b0000;
                        state_d = S_OFF;
                    end else begin
                        cnt_d = cnt_inc_c;
                    end
                end
            end
            S_OFF: begin
                if (tick) begin
                    if (cnt_inc_c == CNT_W'(OFF_TICKS)) begin
                        cnt_d = '0;
                        if (idx_q == len_q - ADDR_W'(1)) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + ADDR_W'(1);
                            state_d = S_FETCH;
                        end
                    end else begin
                        cnt_d = cnt_inc_c;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // abort overrides every transition out of a busy state
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            idx_d   = idx_q;
            cnt_d   = '0;
            led_d   = 4'b0000;
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

endmodule

// File: tb/tb_sequence_player.sv
// Bench for sequence_player: constant vector table, spec-level random model
// and hand-driven timing sequences (latency, tick alignment, abort, reset).
module tb_sequence_player;

    localparam int ON_T = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] length = '0;
    logic [3:0] rd_addr;
    logic [1:0] rd_data = '0;
    logic [3:0] led;
    logic       busy;
    logic       done;
    logic [3:0] pos;
    logic [7:0] rom_bits = '0;

    int total = 0;
    int bad = 0;

    sequence_player dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .abort(abort),
        .length(length), .rd_addr(rd_addr), .rd_data(rd_data), .led(led),
        .busy(busy), .done(done), .pos(pos)
    );

    always #5 clk = ~clk;

    // synchronous ROM with one clock of read latency
    always @(posedge clk) rd_data <= rom_bits[{rd_addr[1:0], 1'b0} +: 2];

    typedef struct {
        logic [3:0]  len;
        logic [7:0]  rom;
        int          runs;
        logic [15:0] leds;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // One cycle: after the negedge, outputs show the current state; drive inputs for the next edge
    task automatic cyc(input bit t, input bit s, input bit a);
        @(negedge clk);
        tick = t;
        start = s;
        abort = a;
    endtask

    // Reference: entry i shows 1<<rom[i] for i < min(len, 4)
    function automatic logic [15:0] model_leds(input logic [7:0] rom, input logic [3:0] len);
        logic [15:0] r = '0;
        int n = (len > 4) ? 4 : int'(len);
        for (int i = 0; i < n; i++) r[4*i +: 4] = 4'b0001 << rom[2*i +: 2];
        return r;
    endfunction

    task automatic play_and_check(input string name, input logic [3:0] len, input logic [7:0] rom,
                                  input int period, input int exp_runs, input logic [15:0] exp_leds);
        int runs = 0, tick_cnt = 0, done_cnt = 0;
        bit in_run = 0, last_t = 0, finished = 0, t;
        logic [3:0] got_led [4];
        logic [3:0] got_addr [4];
        rom_bits = rom;
        length = len;
        cyc(0, 1, 0);
        for (int c = 0; c < 3000 && !finished; c++) begin
            t = (period == 0) ? ($urandom_range(0, 2) == 0) : ((c % period) == period - 1);
            cyc(t, 0, 0);
            if (led != 4'b0000) begin
                if (!$onehot(led)) chk({name, " onehot"}, int'(led), 1);
                if (!in_run) begin
                    in_run = 1;
                    tick_cnt = 0;
                    if (runs < 4) begin
                        got_led[runs] = led;
                        got_addr[runs] = rd_addr;
                    end
                    runs++;
                end
                if (t) tick_cnt++;
                last_t = t;
            end else if (in_run) begin
                in_run = 0;
                chk({name, " lit ticks"}, tick_cnt, ON_T);
                chk({name, " lit ends on tick"}, int'(last_t), 1);
            end
            if (done) done_cnt++;
            if (done_cnt > 0 && !busy) finished = 1;
        end
        if (!finished) chk({name, " timeout"}, 0, 1);
        chk({name, " runs"}, runs, exp_runs);
        for (int i = 0; i < exp_runs && i < runs && i < 4; i++) begin
            chk({name, " led"}, int'(got_led[i]), int'(exp_leds[4*i +: 4]));
            chk({name, " addr"}, int'(got_addr[i]), i);
        end
        chk({name, " done count"}, done_cnt, 1);
        chk({name, " busy after"}, int'(busy), 0);
    endtask

    initial begin
        vec_t vecs [6];
        logic [3:0] l;
        logic [7:0] r;
        int guard;

        vecs[0] = '{4'd4,  8'b01_11_00_10, 4, 16'b0010_1000_0001_0100};
        vecs[1] = '{4'd0,  8'b01_11_00_10, 0, 16'h0000};
        vecs[2] = '{4'd7,  8'b00_11_10_01, 4, 16'b0001_1000_0100_0010};
        vecs[3] = '{4'd1,  8'b00_00_00_11, 1, 16'b0000_0000_0000_1000};
        vecs[4] = '{4'd2,  8'b11_11_00_00, 2, 16'b0000_0000_0001_0001};
        vecs[5] = '{4'd15, 8'b01_10_11_11, 4, 16'b0010_0100_1000_1000};

        // reset and idle
        repeat (5) @(negedge clk);
        chk("reset led", int'(led), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset rd_addr", int'(rd_addr), 0);
        chk("reset pos", int'(pos), 0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0);
            cyc(0, 0, 0);
        end
        cyc(0, 0, 0);
        chk("idle ticks busy", int'(busy), 0);
        chk("idle ticks led", int'(led), 0);

        // start with abort in IDLE: abort wins
        length = 4'd4;
        cyc(0, 1, 1);
        cyc(0, 0, 0);
        chk("start+abort busy", int'(busy), 0);

        // zero length: done in the clk after start
        length = 4'd0;
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        chk("len0 done", int'(done), 1);
        chk("len0 led", int'(led), 0);
        cyc(0, 0, 0);
        chk("len0 done pulse", int'(done), 0);
        chk("len0 busy after", int'(busy), 0);

        // vector table, tick every 4 clk
        foreach (vecs[i])
            play_and_check($sformatf("vec%0d", i), vecs[i].len, vecs[i].rom, 4, vecs[i].runs, vecs[i].leds);

        // latency, tick alignment at ON entry, ignored start in OFF
        rom_bits = 8'b01_11_00_10;
        length = 4'd4;
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        chk("lat fetch led", int'(led), 0);
        chk("lat fetch rd_addr", int'(rd_addr), 0);
        chk("lat fetch busy", int'(busy), 1);
        cyc(1, 0, 0);
        chk("lat wait led", int'(led), 0);
        cyc(1, 0, 0);
        chk("lat on led", int'(led), 4);
        cyc(0, 0, 0);
        chk("align after 1 tick", int'(led), 4);
        cyc(1, 0, 0);
        chk("align still lit", int'(led), 4);
        cyc(0, 1, 0);
        chk("align off", int'(led), 0);
        cyc(1, 0, 0);
        chk("start in off pos", int'(pos), 0);
        chk("start in off rd_addr", int'(rd_addr), 0);
        chk("start in off busy", int'(busy), 1);
        cyc(0, 0, 0);
        chk("next fetch rd_addr", int'(rd_addr), 1);
        chk("next fetch pos", int'(pos), 1);
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        chk("abort fetch busy", int'(busy), 0);

        // abort during ON of entry 2
        length = 4'd4;
        cyc(0, 1, 0);
        guard = 0;
        while (!(led != 0 && pos == 2) && guard < 200) begin
            cyc(guard[0], 0, 0);
            guard++;
        end
        chk("abort reach pos2", int'(guard < 200), 1);
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        chk("abort led", int'(led), 0);
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        guard = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 0);
            if (done) guard++;
        end
        chk("abort no done", guard, 0);
        play_and_check("replay", 4'd4, 8'b01_11_00_10, 4, 4, 16'b0010_1000_0001_0100);

        // async reset during ON
        length = 4'd3;
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("rst pre led", int'(led != 0), 1);
        #2 reset = 1'b0;
        #1;
        chk("async rst led", int'(led), 0);
        chk("async rst busy", int'(busy), 0);
        cyc(0, 0, 0);
        reset = 1'b1;
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        chk("post rst busy", int'(busy), 0);
        chk("post rst led", int'(led), 0);

        // randomized playbacks against the reference model
        for (int i = 0; i < 20; i++) begin
            l = 4'($urandom_range(0, 9));
            r = 8'($urandom);
            play_and_check($sformatf("rnd%0d", i), l, r, 0, (l > 4) ? 4 : int'(l), model_leds(r, l));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
